// File: rtl/wb_tx_uart_target.sv
// Wishbone classic target that buffers TXDATA writes in a FIFO and sends them as 8N1 serial frames.
// State | meaning: IDLE line high, waiting for data | START start bit | DATA 8 data bits LSB first | STOP stop bit.
module wb_tx_uart_target #(
  parameter int FIFO_ADR_WIDTH  = 4,
  parameter int DEFAULT_DIVISOR = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        uart_int_o,
  output logic        uart_tx_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_strobe_o
);
  localparam int AW = FIFO_ADR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [15:0] RESET_DIV = 16'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  tx_state_t state, state_d;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic        fifo_empty, fifo_full, push, pop;
  logic [7:0]  fifo_head;

  logic        req, adr_bad, wr_txdata, wr_ctrl, wr_div, rd_req, ack_d, err_d;
  logic [2:0]  idx;
  logic [31:0] rd_val, status;
  logic        irq_en;
  logic [15:0] divisor, reload, baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shifter;
  logic        bit_end, tx_idle;
  logic        unused;

  assign unused = ^{wb_sel_i, wb_dat_i[31:16], wb_adr_i[1:0]};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level      = wr_ptr - rd_ptr;
  assign fifo_head  = mem[rd_ptr[AW-1:0]];
  assign tx_idle    = fifo_empty && (state == IDLE);

  // Bus decode; the ~ack/~err term keeps a held strobe from being acked twice.
  assign req       = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
  assign idx       = wb_adr_i[4:2];
  assign adr_bad   = (wb_adr_i[23:5] != 19'd0) || idx[2];
  assign wr_txdata = req && wb_we_i && !adr_bad && (idx == 3'd0);
  assign wr_ctrl   = req && wb_we_i && !adr_bad && (idx == 3'd2);
  assign wr_div    = req && wb_we_i && !adr_bad && (idx == 3'd3);
  assign rd_req    = req && !wb_we_i && !adr_bad;
  // A write to a full FIFO waits for a pop; it then pushes and acks on the same edge.
  assign push      = wr_txdata && (!fifo_full || pop);
  assign ack_d     = req && !adr_bad && !(wr_txdata && !push);
  assign err_d     = req && adr_bad;

  always_comb begin
    status = '0;
    status[0] = fifo_full;
    status[1] = fifo_empty;
    status[2] = tx_idle;
    status[8 +: AW+1] = level;
    case (idx)
      3'd1:    rd_val = status;
      3'd2:    rd_val = {31'd0, irq_en};
      3'd3:    rd_val = {16'd0, divisor};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
      irq_en     <= 1'b0;
      divisor    <= RESET_DIV;
      uart_int_o <= 1'b0;
    end else begin
      wb_ack_o   <= ack_d;
      wb_err_o   <= err_d;
      wb_dat_o   <= rd_req ? rd_val : 32'd0;
      uart_int_o <= irq_en && fifo_empty;
      if (wr_ctrl) irq_en <= wb_dat_i[0];
      if (wr_div)  divisor <= wb_dat_i[15:0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
  end

  // A divisor of 0 is treated as 1; it is sampled only when a bit starts.
  assign reload  = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  assign bit_end = (baud_cnt == 16'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) begin
               state_d = START;
               pop     = 1'b1;
             end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_d = STOP;
      STOP:  if (bit_end) begin
               if (!fifo_empty) begin
                 state_d = START;
                 pop     = 1'b1;
               end else begin
                 state_d = IDLE;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      uart_tx_o   <= 1'b1;
      tx_byte_o   <= 8'd0;
      tx_strobe_o <= 1'b0;
      shifter     <= 8'd0;
      baud_cnt    <= 16'd0;
      bit_cnt     <= 3'd0;
    end else if (pop) begin
      shifter     <= fifo_head;
      tx_byte_o   <= fifo_head;
      tx_strobe_o <= 1'b1;
      uart_tx_o   <= 1'b0;
      baud_cnt    <= reload;
      bit_cnt     <= 3'd0;
    end else begin
      tx_strobe_o <= 1'b0;
      case (state)
        START: begin
          if (bit_end) begin
            uart_tx_o <= shifter[0];
            baud_cnt  <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= reload;
            if (bit_cnt == 3'd7) begin
              uart_tx_o <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shifter   <= {1'b0, shifter[7:1]};
              uart_tx_o <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          uart_tx_o <= 1'b1;
          if (!bit_end) baud_cnt <= baud_cnt - 16'd1;
        end
        default: uart_tx_o <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_tx_uart_target.sv
// Directed bench for wb_tx_uart_target: register access, serial framing, FIFO stall, errors and reset.
module tb_wb_tx_uart_target;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] adr;
  logic [31:0] dat_w, dat_r;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, uart_int, uart_tx, strobe;
  logic [7:0]  tx_byte;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;
  bit tx_hist [32768];
  bit int_hist [32768];
  logic [7:0] cap_byte [$];
  int cap_cyc [$];

  logic        b_ack, b_err;
  logic [31:0] b_dat;
  int          b_waits, b_cyc;

  localparam logic [23:0] A_TX = 24'h0, A_ST = 24'h4, A_CTRL = 24'h8, A_DIV = 24'hC;

  wb_tx_uart_target dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
    .wb_err_o(err), .uart_int_o(uart_int), .uart_tx_o(uart_tx), .tx_byte_o(tx_byte),
    .tx_strobe_o(strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (cyc_n < 32768) begin
      tx_hist[cyc_n]  = uart_tx;
      int_hist[cyc_n] = uart_int;
    end
    if (strobe === 1'b1) begin
      cap_byte.push_back(tx_byte);
      cap_cyc.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns one idle cycle after termination.
  task automatic bus(input logic w, input logic [23:0] a, input logic [31:0] d, input int limit);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    b_waits = 0; b_ack = 1'b0; b_err = 1'b0; b_dat = '0;
    while (b_waits < limit && !b_ack && !b_err) begin
      @(negedge clk);
      b_waits++;
      b_ack = ack; b_err = err; b_dat = dat_r;
    end
    b_cyc = cyc_n;
    chk($sformatf("bus_term_%0h", a), {31'd0, b_ack | b_err}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 20);
    chk($sformatf("wr_ack_%0h", a), {30'd0, b_ack, b_err}, 32'd2);
  endtask

  task automatic rd(input logic [23:0] a, input logic [31:0] exp, input string tag);
    bus(1'b0, a, 32'd0, 20);
    chk({tag, "_ack"}, {30'd0, b_ack, b_err}, 32'd2);
    chk(tag, b_dat, exp);
  endtask

  task automatic wait_caps(input int n, input int limit);
    int w = 0;
    while (cap_byte.size() < n && w < limit) begin
      @(negedge clk);
      w++;
    end
    chk("cap_count", cap_byte.size(), n);
  endtask

  task automatic check_frame(input string tag, input int s, input logic [7:0] b, input int div);
    int errs = 0;
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * div; k++)
      if (tx_hist[s + k] !== bits[k / div]) errs++;
    chk(tag, errs, 0);
  endtask

  initial begin
    int s1, base, acks;
    logic seen;
    rst = 1'b1; adr = '0; dat_w = '0; sel = 4'hF; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {27'd0, ack, err, uart_int, uart_tx, strobe}, 32'b00010);
    chk("rst_byte", tx_byte, 0);
    chk("rst_dat", dat_r, 0);
    rst = 1'b0;
    @(negedge clk);
    rd(A_ST, 32'h6, "status_rst");
    rd(A_DIV, 32'd16, "div_rst");

    // single byte at 4 clocks per bit
    wr(A_DIV, 4);
    rd(A_DIV, 4, "div4");
    wr(A_TX, 8'h55);
    chk("wr55_waits", b_waits, 1);
    s1 = b_cyc;
    wait_caps(1, 100);
    chk("byte55", cap_byte[0], 8'h55);
    chk("start_latency", cap_cyc[0], s1 + 1);
    repeat (45) @(negedge clk);
    check_frame("frame55", cap_cyc[0], 8'h55, 4);
    chk("idle_after55", tx_hist[cap_cyc[0] + 40], 1);
    rd(A_ST, 32'h6, "status_idle");

    // back-to-back frames with interrupt
    wr(A_CTRL, 1);
    rd(A_CTRL, 1, "ctrl1");
    chk("int_empty", uart_int, 1);
    wr(A_TX, 8'h41); wr(A_TX, 8'h42); wr(A_TX, 8'h43);
    chk("int_busy", uart_int, 0);
    rd(A_ST, 32'h200, "status_lvl2");
    wait_caps(4, 200);
    repeat (45) @(negedge clk);
    s1 = cap_cyc[1];
    chk("gap12", cap_cyc[2], s1 + 40);
    chk("gap23", cap_cyc[3], s1 + 80);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_byte%0d", i), cap_byte[1 + i], 8'h41 + i);
      check_frame($sformatf("b2b_frame%0d", i), cap_cyc[1 + i], 8'h41 + i, 4);
    end
    chk("int_last_pop", int_hist[cap_cyc[3]], 0);
    chk("int_after_pop", int_hist[cap_cyc[3] + 1], 1);

    // full-FIFO stall
    wr(A_DIV, 100);
    base = cap_byte.size();
    for (int i = 0; i < 17; i++) begin
      wr(A_TX, 8'h60 + i);
      chk($sformatf("fill_waits%0d", i), b_waits, 1);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TX; dat_w = 32'hEE;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= ack; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("stall_drop_noack", seen, 0);
    rd(A_ST, 32'h1001, "status_full");
    bus(1'b1, A_TX, 8'h71, 2000);
    chk("stall_ack", {30'd0, b_ack, b_err}, 32'd2);
    chk("stall_long", b_waits > 100, 1);
    wait_caps(base + 2, 10);
    chk("stall_ack_at_pop", b_cyc, cap_cyc[base + 1]);
    rd(A_ST, 32'h1001, "status_full2");
    wait_caps(base + 18, 20000);
    repeat (1010) @(negedge clk);
    for (int i = 0; i < 18; i++)
      chk($sformatf("order%0d", i), cap_byte[base + i], (i < 17) ? 8'h60 + i : 8'h71);
    rd(A_ST, 32'h6, "status_drained");

    // bus errors and zero divisor
    bus(1'b0, 24'h14, 0, 20);
    chk("err_idx5", {30'd0, b_ack, b_err}, 32'd1);
    chk("err_idx5_dat", b_dat, 0);
    chk("err_one_cycle", err, 0);
    bus(1'b1, 24'h20, 32'h77, 20);
    chk("err_hi_adr", {30'd0, b_ack, b_err}, 32'd1);
    rd(A_ST, 32'h6, "status_after_err");
    bus(1'b1, 24'h2C, 32'h3, 20);
    chk("err_hi_div", {30'd0, b_ack, b_err}, 32'd1);
    rd(A_DIV, 100, "div_unchanged");
    wr(A_DIV, 0);
    rd(A_DIV, 0, "div0");
    base = cap_byte.size();
    wr(A_TX, 8'hA5);
    wait_caps(base + 1, 50);
    repeat (15) @(negedge clk);
    chk("byteA5", cap_byte[base], 8'hA5);
    check_frame("frameA5_div0", cap_cyc[base], 8'hA5, 1);
    chk("idle_afterA5", tx_hist[cap_cyc[base] + 10], 1);

    // handshake: held strobe, and strobe dropped before sampling
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_ST;
    acks = 0;
    repeat (6) begin @(negedge clk); acks += int'(ack); end
    cyc = 1'b0; stb = 1'b0;
    chk("held_stb_acks", acks, 3);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_TX; dat_w = 32'h99;
    #2;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= ack; end
    chk("glitch_noack", seen, 0);
    rd(A_ST, 32'h6, "status_no_push");

    // asynchronous reset mid-frame
    wr(A_DIV, 4);
    wr(A_TX, 8'h3C);
    wr(A_TX, 8'h11);
    repeat (9) @(negedge clk);
    chk("pre_rst_tx", uart_tx, 0);
    chk("pre_rst_byte", tx_byte, 8'h3C);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctl", {27'd0, ack, err, uart_int, uart_tx, strobe}, 32'b00010);
    chk("async_rst_byte", tx_byte, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(A_ST, 32'h6, "status_post_rst");
    rd(A_DIV, 16, "div_post_rst");
    rd(A_CTRL, 0, "ctrl_post_rst");
    chk("int_post_rst", uart_int, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_tx_uart_target.md
# wb_tx_uart_target

Wishbone classic-cycle target that terminates the UART port of the OR10 test-suite SoC. It accepts CPU writes to a transmit register and buffers them in a FIFO. It serialises each byte as 8N1 on `uart_tx_o` and raises `uart_int_o` when the FIFO drains. A byte-capture strobe lets the bench log console output without decoding the serial line.

## Interface
- `FIFO_ADR_WIDTH`, default 4: FIFO depth is 2^N entries (16).
- `DEFAULT_DIVISOR`, default 16: reset value of DIVISOR, in clocks per bit.
- `wb_clk_i`  in  1  system clock.
- `wb_rst_i`  in  1  reset.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `wb_adr_i`  in  24  byte address. Only [4:2] are decoded; [23:5] must be 0.
- `wb_dat_i`  in  32  write data; the register value is in [15:0].
- `wb_dat_o`  out  32  read data; zero-extended, 0 when not acking a read.
- `wb_sel_i`  in  4  byte selects; ignored (all accesses are word-wide).
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.
- `uart_int_o`  out  1  interrupt, level, registered.
- `uart_tx_o`  out  1  serial line; idles high.
- `tx_byte_o`  out  8  byte currently being loaded into the shifter.
- `tx_strobe_o`  out  1  one-cycle pulse when `tx_byte_o` is valid.

## Operation
- Register map, by `wb_adr_i[4:2]`:
  - 0 TXDATA (W): push `dat_i[7:0]` into the FIFO. Reads return 0.
  - 1 STATUS (R):
    - bit0 `fifo_full`
    - bit1 `fifo_empty`
    - bit2 `tx_idle`: FIFO empty and shifter in IDLE
    - bits[12:8] FIFO level, 0..2^N
    - Writes are acked and ignored.
  - 2 CTRL (R/W): bit0 `irq_en`, reset 0. Other bits read 0.
  - 3 DIVISOR (R/W): [15:0], reset `DEFAULT_DIVISOR`. Value 0 behaves as 1.
  - Indices 4-7, or any address with [23:5] ≠ 0: `wb_err_o` with the same timing as ack. No side effects.
- FIFO:
  - Circular, with read/write pointers of N+1 bits; full/empty are derived from the pointer MSB compare.
  - A push and a pop in the same cycle leave the level unchanged.
  - Write to TXDATA when full: ack is withheld (wait states) until a pop frees an entry. The push and the ack then happen together. Data is never dropped.
- Transmitter FSM:
  - States: IDLE, START, DATA, STOP.
  - A bit counter (3b) and a baud counter (16b) run the bit timing.
  - IDLE → START when FIFO non-empty. In that same cycle:
    - the FIFO pops;
    - the byte is latched into the shifter;
    - `tx_byte_o` is driven and `tx_strobe_o` pulses.
  - Each state holds DIVISOR cycles.
  - DATA shifts 8 bits, LSB first.
  - STOP → START directly if the FIFO is non-empty (back-to-back frames, with pop and strobe as above); otherwise → IDLE.
  - A DIVISOR write takes effect at the next bit boundary.
- Interrupt: `uart_int_o` ← `irq_en` & `fifo_empty`, registered.

## Timing
- Reset values:
  - `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0
  - `uart_tx_o`=1, `uart_int_o`=0
  - `tx_byte_o`=0, `tx_strobe_o`=0
  - FIFO empty, FSM in IDLE
- Reset mid-frame or mid-cycle: everything returns to reset values immediately. FIFO contents are lost.
- Ack/err:
  - Registered: asserted the cycle after `cyc&stb` is sampled high (1 wait state), for exactly one cycle.
  - Next-state term is `cyc&stb&~ack&~err`, which allows back-to-back cycles without double acks.
  - If `stb` drops before ack, no ack is issued and there are no side effects.
- Register-write and read-data timing:
  - A register write commits on the ack edge.
  - Read data is valid while `wb_ack_o` is high.
  - A STATUS read reflects state one cycle before ack.
- Serial timing:
  - `uart_tx_o` is registered. The start bit goes low one cycle after the FIFO becomes non-empty in IDLE.
  - Frame length is exactly 10×DIVISOR cycles.
  - Back-to-back frames have no idle gap.
- Write-to-start latency: TXDATA ack edge → `uart_tx_o` low is 1 cycle when idle.

## Test plan
- Reset check: reset asserted asynchronously mid-frame → all outputs at reset values without waiting for a clock edge. After release, STATUS reads 0x0000_0006.
- Single byte: DIVISOR=4, write 0x55 to TXDATA → `tx_strobe_o` with `tx_byte_o`=0x55. `uart_tx_o` pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then high.
- Back-to-back with interrupt: CTRL=1, write 0x41, 0x42, 0x43 → three contiguous 40-cycle frames with no idle gap. `uart_int_o` is low while the FIFO holds data and high after the last pop.
- Full-FIFO stall: DIVISOR=100, write 18 bytes → writes 1-17 ack in 1 wait state (byte 1 pops immediately, leaving 16 entries). Write 18 is held until the next pop (~1000 cycles). Level and order are preserved: the bench captures all 18 bytes in order.
- Bus errors: read word index 5, or address 0x000020 → `wb_err_o` pulses, no ack, no state change. A DIVISOR write of 0 yields 1-cycle bits.
- Handshake: `stb` held for 3 consecutive classic cycles to STATUS → exactly one ack per cycle. `stb` dropped before ack → no ack, no push.
